lmc_core: RTL and testbench

LMC_CORE -- requirements
Module: lmc_core

---
 rtl/lmc_pkg.sv | 32 +++
 rtl/lmc_alu.sv | 28 ++
 rtl/lmc_core.sv | 190 +++++++++++++++++++
 tb/tb_lmc_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmc_pkg.sv
// lmc_pkg -- definitions shared by the little-man-computer core and its ALU.
//   state_e  : FSM state encoding. It is also driven out on the core's 2-bit
//              state port.
//   opcode_e : the instruction opcodes. Codes 11..15 are not listed and decode
//              as NOP.
//   OPCODE_W : width of the opcode field at the top of each instruction word.
package lmc_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT = 4'd0,
        OP_LDA = 4'd1,
        OP_STA = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_LDI = 4'd5,
        OP_OUT = 4'd6,
        OP_BRA = 4'd7,
        OP_BRZ = 4'd8,
        OP_BRP = 4'd9,
        OP_LDK = 4'd10
    } opcode_e;

endpackage

// File: rtl/lmc_alu.sv
// lmc_alu -- modular add/subtract unit used by the accumulator.
//   a, b      : operands (DATA_W)
//   sub       : 0 = a+b, 1 = a-b
//   result    : sum or difference, modulo 2**DATA_W
//   carry_out : carry-out on add; no-borrow (a >= b) on subtract
module lmc_alu
    import lmc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    // Subtraction is a + ~b + 1. Its carry-out is set exactly when no borrow
    // occurs, which is the case a >= b.
    assign b_eff     = sub ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
    assign result    = sum[DATA_W-1:0];
    assign carry_out = sum[DATA_W];

endmodule

// File: rtl/lmc_core.sv
// lmc_core -- small accumulator machine with a program memory and a data memory.
//   clk, reset_count       : clock; asynchronous active-high reset
//   start                  : run request. It is honoured only in IDLE or HALT
//                            and restarts execution from pc 0.
//   prog_we/addr/data      : program-memory write port. It is honoured only in
//                            IDLE or HALT. An instruction word is
//                            {opcode[3:0], operand}.
//   in_data/valid/ready    : input stream consumed by LDI
//   out_data/out_valid     : value latched by OUT, plus a one-cycle strobe
//   pc, acc, carry, zero   : architectural state
//   halted, state          : FSM observation (state uses the state_e encoding)
//
// Handshake (in_valid/in_ready): in_ready is high only while an LDI is waiting
// in EXEC. A word transfers on a rising edge where in_valid and in_ready are
// both high. Until that edge the core holds pc, acc and state.
//
// Every non-stalled instruction takes two cycles, one in FETCH and one in EXEC.
// The reset clears the registers only. Program and data memory keep their
// contents.
module lmc_core
    import lmc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_count,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [OPCODE_W+ADDR_W-1:0] prog_data,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic [ADDR_W-1:0]     pc,
    output logic [DATA_W-1:0]     acc,
    output logic                  carry,
    output logic                  zero,
    output logic                  halted,
    output logic [1:0]            state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IR_W  = OPCODE_W + ADDR_W;

    logic [IR_W-1:0]   pmem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    state_e            st_q, st_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [IR_W-1:0]   ir_q, ir_nxt;
    logic [DATA_W-1:0] acc_q, acc_nxt;
    logic              carry_q, carry_nxt;
    logic [DATA_W-1:0] out_data_q, out_data_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic              in_ready_c;
    logic              dmem_we;

    logic [OPCODE_W-1:0] ir_op;
    logic [ADDR_W-1:0]   ir_operand;
    logic [DATA_W-1:0]   dmem_rd;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                idle_or_halt;

    assign ir_op        = ir_q[IR_W-1:ADDR_W];
    assign ir_operand   = ir_q[ADDR_W-1:0];
    assign dmem_rd      = dmem[ir_operand];
    assign idle_or_halt = (st_q == IDLE) || (st_q == HALT);

    lmc_alu #(.DATA_W(DATA_W)) u_alu (
        .a         (acc_q),
        .b         (dmem_rd),
        .sub       (ir_op == OP_SUB),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Program memory. Writes are blocked while a program is running, so the
    // running program cannot be changed underneath the fetch.
    always_ff @(posedge clk) begin
        if (prog_we && idle_or_halt) begin
            pmem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[ir_operand] <= acc_q;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_nxt;
            ir_q        <= ir_nxt;
            acc_q       <= acc_nxt;
            carry_q     <= carry_nxt;
            out_data_q  <= out_data_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        st_nxt        = st_q;
        pc_nxt        = pc_q;
        ir_nxt        = ir_q;
        acc_nxt       = acc_q;
        carry_nxt     = carry_q;
        out_data_nxt  = out_data_q;
        out_valid_nxt = 1'b0;
        in_ready_c    = 1'b0;
        dmem_we       = 1'b0;

        case (st_q)
            IDLE, HALT: begin
                if (start) begin
                    st_nxt = FETCH;
                    pc_nxt = '0;
                end
            end
            FETCH: begin
                ir_nxt = pmem[pc_q];
                pc_nxt = pc_q + 1'b1;
                st_nxt = EXEC;
            end
            EXEC: begin
                st_nxt = FETCH;
                case (ir_op)
                    OP_HLT: st_nxt = HALT;
                    OP_LDA: acc_nxt = dmem_rd;
                    OP_STA: dmem_we = 1'b1;
                    OP_ADD, OP_SUB: begin
                        acc_nxt   = alu_result;
                        carry_nxt = alu_carry;
                    end
                    OP_LDI: begin
                        in_ready_c = 1'b1;
                        if (in_valid) begin
                            acc_nxt = in_data;
                        end else begin
                            st_nxt = EXEC;
                        end
                    end
                    OP_OUT: begin
                        out_data_nxt  = acc_q;
                        out_valid_nxt = 1'b1;
                    end
                    OP_BRA: pc_nxt = ir_operand;
                    OP_BRZ: if (acc_q == '0) pc_nxt = ir_operand;
                    OP_BRP: if (!acc_q[DATA_W-1]) pc_nxt = ir_operand;
                    OP_LDK: acc_nxt = DATA_W'(ir_operand);
                    default: ;
                endcase
            end
            default: st_nxt = IDLE;
        endcase
    end

    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign zero      = (acc_q == '0);
    assign halted    = (st_q == HALT);
    assign state     = st_q;

endmodule

// File: tb/tb_lmc_core.sv
// tb_lmc_core -- directed test sequence for lmc_core with the default sizes
// (DATA_W=8, ADDR_W=4).
module tb_lmc_core;
    import lmc_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int IR_W   = 4 + ADDR_W;

    logic              clk = 1'b0;
    logic              reset_count = 1'b1;
    logic              start = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [IR_W-1:0]   prog_data = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic              zero;
    logic              halted;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    lmc_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset_count (reset_count),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .pc          (pc),
        .acc         (acc),
        .carry       (carry),
        .zero        (zero),
        .halted      (halted),
        .state       (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: each out_valid strobe must match the oldest expected value
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL out_strobe: observed unexpected out_data %0h, required no output", out_data);
            end else begin
                automatic logic [DATA_W-1:0] e = exp_q.pop_front();
                assert (out_data === e) else begin
                    errors++;
                    $error("FAIL out_stream: observed %0h required %0h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IR_W-1:0] ins(input logic [3:0] op, input logic [ADDR_W-1:0] operand);
        return {op, operand};
    endfunction

    task automatic load(input logic [ADDR_W-1:0] a, input logic [IR_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int limit);
        int n = 0;
        while (!halted && n < limit) begin
            tick();
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic load_sum_prog();
        load(4'd0, ins(OP_LDK, 4'd7));
        load(4'd1, ins(OP_STA, 4'd2));
        load(4'd2, ins(OP_LDK, 4'd5));
        load(4'd3, ins(OP_ADD, 4'd2));
        load(4'd4, ins(OP_OUT, 4'd0));
        load(4'd5, ins(OP_HLT, 4'd0));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        tick();
        reset_count = 1'b0;
        tick();

        // 7 + 5 = 12, then OUT and HLT
        load_sum_prog();
        exp_q.push_back(8'd12);
        start_run();
        check("sum_fetch_state", {30'd0, state}, 32'(FETCH));
        check("sum_fetch_pc", {28'd0, pc}, 32'd0);
        repeat (9) tick();
        check("sum_no_out_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("sum_out_valid", {31'd0, out_valid}, 32'd1);
        check("sum_out_data", {24'd0, out_data}, 32'd12);
        check("sum_carry", {31'd0, carry}, 32'd0);
        tick();
        check("sum_out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("sum_out_data_hold", {24'd0, out_data}, 32'd12);
        check("sum_not_halted_11", {31'd0, halted}, 32'd0);
        tick();
        check("sum_halted_12", {31'd0, halted}, 32'd1);
        check("sum_state_halt", {30'd0, state}, 32'(HALT));
        check("sum_pc", {28'd0, pc}, 32'd6);

        // Countdown 3 -> 2,1,0
        load(4'd0, ins(OP_LDK, 4'd1));
        load(4'd1, ins(OP_STA, 4'd0));
        load(4'd2, ins(OP_LDK, 4'd3));
        load(4'd3, ins(OP_SUB, 4'd0));
        load(4'd4, ins(OP_OUT, 4'd0));
        load(4'd5, ins(OP_BRZ, 4'd7));
        load(4'd6, ins(OP_BRA, 4'd3));
        load(4'd7, ins(OP_HLT, 4'd0));
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd0);
        start_run();
        wait_halt("cd_halt", 100);
        check("cd_acc", {24'd0, acc}, 32'd0);
        check("cd_carry", {31'd0, carry}, 32'd1);
        check("cd_pc", {28'd0, pc}, 32'd8);
        check("cd_all_out", exp_q.size(), 32'd0);

        // LDI stall, then handshake completes
        load(4'd0, ins(OP_LDI, 4'd0));
        load(4'd1, ins(OP_HLT, 4'd0));
        start_run();
        tick();
        check("ldi_state", {30'd0, state}, 32'(EXEC));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ldi_stall_ready", {31'd0, in_ready}, 32'd1);
            check("ldi_stall_pc", {28'd0, pc}, 32'd1);
        end
        check("ldi_stall_state", {30'd0, state}, 32'(EXEC));
        in_valid = 1'b1;
        in_data  = 8'h2A;
        tick();
        in_valid = 1'b0;
        check("ldi_acc", {24'd0, acc}, 32'h2A);
        check("ldi_ready_drop", {31'd0, in_ready}, 32'd0);
        check("ldi_state_fetch", {30'd0, state}, 32'(FETCH));
        wait_halt("ldi_halt", 20);

        // Wrap-around ADD/SUB, LDA and BRP. Reset first so carry starts at 0.
        reset_count = 1'b1;
        tick();
        reset_count = 1'b0;
        load(4'd0,  ins(OP_LDK, 4'd1));
        load(4'd1,  ins(OP_STA, 4'd1));
        load(4'd2,  ins(OP_LDI, 4'd0));
        load(4'd3,  ins(OP_ADD, 4'd1));
        load(4'd4,  ins(OP_OUT, 4'd0));
        load(4'd5,  ins(OP_SUB, 4'd1));
        load(4'd6,  ins(OP_OUT, 4'd0));
        load(4'd7,  ins(OP_BRP, 4'd9));
        load(4'd8,  ins(OP_LDA, 4'd1));
        load(4'd9,  ins(OP_OUT, 4'd0));
        load(4'd10, ins(OP_BRP, 4'd12));
        load(4'd11, ins(OP_OUT, 4'd0));
        load(4'd12, ins(OP_HLT, 4'd0));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        start_run();
        repeat (6) tick();
        check("alu_ldi_ff", {24'd0, acc}, 32'hFF);
        check("alu_carry_before", {31'd0, carry}, 32'd0);
        in_valid = 1'b0;
        repeat (2) tick();
        check("add_wrap_acc", {24'd0, acc}, 32'h00);
        check("add_wrap_carry", {31'd0, carry}, 32'd1);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        repeat (4) tick();
        check("sub_wrap_acc", {24'd0, acc}, 32'hFF);
        check("sub_wrap_carry", {31'd0, carry}, 32'd0);
        check("sub_wrap_zero", {31'd0, zero}, 32'd0);
        wait_halt("alu_halt", 40);
        check("brp_acc", {24'd0, acc}, 32'h01);
        check("brp_pc", {28'd0, pc}, 32'd13);
        check("alu_all_out", exp_q.size(), 32'd0);

        // Reset in the middle of STA's EXEC cycle
        load_sum_prog();
        start_run();
        repeat (3) tick();
        check("mid_state_exec", {30'd0, state}, 32'(EXEC));
        check("mid_acc", {24'd0, acc}, 32'd7);
        reset_count = 1'b1;
        #1;
        check("mid_rst_state", {30'd0, state}, 32'd0);
        check("mid_rst_pc", {28'd0, pc}, 32'd0);
        check("mid_rst_acc", {24'd0, acc}, 32'd0);
        check("mid_rst_carry", {31'd0, carry}, 32'd0);
        check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_halted", {31'd0, halted}, 32'd0);
        tick();
        reset_count = 1'b0;
        tick();
        exp_q.push_back(8'd12);
        start_run();
        wait_halt("rerun_halt", 30);
        check("rerun_acc", {24'd0, acc}, 32'd12);
        check("rerun_out_data", {24'd0, out_data}, 32'd12);

        // Program write and start during a run are both ignored
        exp_q.push_back(8'd12);
        start_run();
        tick();
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = ins(OP_HLT, 4'd0);
        start     = 1'b1;
        repeat (2) tick();
        check("busy_start_pc", {28'd0, pc}, 32'd2);
        check("busy_start_state", {30'd0, state}, 32'(EXEC));
        prog_we = 1'b0;
        start   = 1'b0;
        wait_halt("busy_halt", 30);
        exp_q.push_back(8'd12);
        start_run();
        wait_halt("reexec_halt", 30);
        check("reexec_acc", {24'd0, acc}, 32'd12);
        tick();
        check("final_all_out", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
